ahb_slave_arbiter: RTL and testbench

- Shares the single FPGA-fabric register-bus slave port (HSEL/HWRITE/HADDR/HWDATA, returning HREADY/HRDATA) between two masters.
- Master 0 is the EMIF-to-bus bridge. Master 1 is an internal requester, such as a config sequencer or debug port.
- Round-robin arbitration, one outstanding 32-bit transfer at a time.
- Slave-response timeout so a hung slave cannot lock up the EMIF host.

---
 rtl/ahb_slave_arbiter.sv | 149 ++++++++++++++
 tb/tb_ahb_slave_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_arbiter.sv
// Two-master round-robin arbiter in front of a single register-bus slave port.
// One transfer in flight; a slave that never answers is cut off after TIMEOUT BUSY cycles.
module ahb_slave_arbiter #(
  parameter int                ADDR_W   = 20,
  parameter int                DATA_W   = 32,
  parameter int                TIMEOUT  = 1024,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_sel,
  input  logic              m0_write,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ready,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_sel,
  input  logic              m1_write,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_sel,
  output logic              s_write,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic              s_ready,
  input  logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        grant,
  output logic              timeout_err,
  input  logic              err_clr
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              ptr_q, ptr_d;       // 1: m1 wins a tie
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              s_sel_q, s_sel_d;
  logic              s_write_q, s_write_d;
  logic [ADDR_W-1:0] s_addr_q, s_addr_d;
  logic [DATA_W-1:0] s_wdata_q, s_wdata_d;
  logic [1:0]        rdy_q, rdy_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              err_q, err_d;
  logic              pick1;
  logic              own_sel;
  logic [DATA_W-1:0] rd;

  assign own_sel = grant_q[1] ? m1_sel : m0_sel;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    s_sel_d   = s_sel_q;
    s_write_d = s_write_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    rdy_d     = 2'b00;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    err_d     = err_q & ~err_clr;
    pick1     = 1'b0;
    rd        = s_ready ? s_rdata : ERR_DATA;
    unique case (state_q)
      IDLE: begin
        if (m0_sel | m1_sel) begin
          pick1     = m1_sel & (~m0_sel | ptr_q);
          grant_d   = pick1 ? 2'b10 : 2'b01;
          s_sel_d   = 1'b1;
          s_write_d = pick1 ? m1_write : m0_write;
          s_addr_d  = pick1 ? m1_addr  : m0_addr;
          s_wdata_d = pick1 ? m1_wdata : m0_wdata;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (s_ready || ((TIMEOUT > 0) && (cnt_q == TO_LAST))) begin
          rdy_d   = grant_q;
          s_sel_d = 1'b0;
          state_d = DONE;
          if (!s_write_q) begin
            if (grant_q[1]) rdata1_d = rd;
            else            rdata0_d = rd;
          end
          if (!s_ready) err_d = 1'b1;
        end
      end
      DONE: begin
        // Waiting for s_ready low guarantees the next transfer sees a fresh rising edge.
        if (!own_sel && !s_ready) begin
          state_d = IDLE;
          ptr_d   = ~grant_q[1];
          cnt_d   = '0;
          grant_d = 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      ptr_q     <= 1'b0;
      cnt_q     <= '0;
      s_sel_q   <= 1'b0;
      s_write_q <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      rdy_q     <= 2'b00;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      s_sel_q   <= s_sel_d;
      s_write_q <= s_write_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      rdy_q     <= rdy_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      err_q     <= err_d;
    end
  end

  assign m0_ready    = rdy_q[0];
  assign m1_ready    = rdy_q[1];
  assign m0_rdata    = rdata0_q;
  assign m1_rdata    = rdata1_q;
  assign s_sel       = s_sel_q;
  assign s_write     = s_write_q;
  assign s_addr      = s_addr_q;
  assign s_wdata     = s_wdata_q;
  assign grant       = grant_q;
  assign timeout_err = err_q;
endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Random two-master / one-slave traffic against a transfer-timeline reference model.
module tb_ahb_slave_arbiter;
  localparam int AW = 20;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam logic [DW-1:0] ERRD = 32'hDEADBEEF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    sel, wr;
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wdata [2];
  logic [1:0]    rdyo;
  logic [DW-1:0] rd0, rd1;
  logic          s_sel, s_write, srdy, terr, err_clr;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata, srdata;
  logic [1:0]    grant;

  ahb_slave_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
    .clk(clk), .rst(rst),
    .m0_sel(sel[0]), .m0_write(wr[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
    .m0_ready(rdyo[0]), .m0_rdata(rd0),
    .m1_sel(sel[1]), .m1_write(wr[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
    .m1_ready(rdyo[1]), .m1_rdata(rd1),
    .s_sel(s_sel), .s_write(s_write), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ready(srdy), .s_rdata(srdata),
    .grant(grant), .timeout_err(terr), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: one transfer timeline (grant edge, completion edge, release edge)
  int            owner = -1;
  int            last  = 1;
  int            g     = 0;
  int            cyc   = 0;
  bit            done  = 1'b0;
  logic          g_wr;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata;
  logic [DW-1:0] e_rd [2];
  bit            e_err = 1'b0;
  logic [1:0]    e_rdy;

  // inputs as sampled at the edge just passed
  logic          p_rst, p_srdy, p_clr;
  logic [1:0]    p_sel, p_wr;
  logic [AW-1:0] p_addr [2];
  logic [DW-1:0] p_wdata [2];
  logic [DW-1:0] p_srdata;

  // agent knobs and slave state
  bit [1:0] auto_en = 2'b00;
  bit       fix = 1'b1;
  int       hang_pct = 0;
  int       clr_pct = 0;
  bit       s_busy = 1'b0;
  int       s_wait = 0;
  int       s_hold = 0;

  task automatic cycle();
    bit tmo;
    p_rst = rst; p_sel = sel; p_wr = wr; p_addr = addr; p_wdata = wdata;
    p_srdy = srdy; p_srdata = srdata; p_clr = err_clr;
    @(negedge clk);
    cyc++;
    e_rdy = 2'b00;
    tmo   = 1'b0;
    if (p_rst) begin
      owner = -1; last = 1; e_rd[0] = '0; e_rd[1] = '0; e_err = 1'b0;
    end else begin
      if (owner < 0) begin
        if (p_sel != 2'b00) begin
          if (p_sel == 2'b11) owner = (last == 0) ? 1 : 0;
          else                owner = p_sel[1] ? 1 : 0;
          g = cyc; done = 1'b0;
          g_wr = p_wr[owner]; g_addr = p_addr[owner]; g_wdata = p_wdata[owner];
        end
      end else if (!done) begin
        if (p_srdy) begin
          done = 1'b1; e_rdy[owner] = 1'b1;
          if (!g_wr) e_rd[owner] = p_srdata;
        end else if (cyc - g == TO) begin
          done = 1'b1; e_rdy[owner] = 1'b1; tmo = 1'b1;
          if (!g_wr) e_rd[owner] = ERRD;
        end
      end else if (!p_sel[owner] && !p_srdy) begin
        last = owner; owner = -1;
      end
      if (tmo)        e_err = 1'b1;
      else if (p_clr) e_err = 1'b0;
    end

    chk("grant", grant, owner < 0 ? 64'd0 : (owner == 1 ? 64'd2 : 64'd1));
    chk("s_sel", s_sel, (owner >= 0) && !done);
    chk("m0_ready", rdyo[0], e_rdy[0]);
    chk("m1_ready", rdyo[1], e_rdy[1]);
    chk("m0_rdata", rd0, e_rd[0]);
    chk("m1_rdata", rd1, e_rd[1]);
    chk("timeout_err", terr, e_err);
    if (owner >= 0) begin
      chk("s_write", s_write, g_wr);
      chk("s_addr", s_addr, g_addr);
      chk("s_wdata", s_wdata, g_wdata);
    end

    // masters: hold request until ready, occasionally walk away mid-transfer
    for (int i = 0; i < 2; i++) begin
      if (sel[i] && rdyo[i]) sel[i] = 1'b0;
      else if (sel[i] && grant[i] && !fix && $urandom_range(63) == 0) sel[i] = 1'b0;
      else if (!sel[i] && !rdyo[i] && !grant[i] && auto_en[i] && $urandom_range(3) == 0) begin
        sel[i] = 1'b1;
        if (fix && i == 0) begin
          wr[0] = 1'b1; addr[0] = 20'h00104; wdata[0] = 32'h11223344;
        end else begin
          wr[i] = 1'($urandom()); addr[i] = AW'($urandom()); wdata[i] = $urandom();
        end
      end
    end

    // slave: delay, then s_ready held 1..5 cycles, or hang
    if (s_busy && !s_sel && !srdy) s_busy = 1'b0;
    if (!s_busy && s_sel) begin
      s_busy = 1'b1;
      if (fix)                                 s_wait = 3;
      else if ($urandom_range(99) < hang_pct)  s_wait = 1000;
      else                                     s_wait = $urandom_range(3);
      s_hold = 1 + $urandom_range(4);
    end
    if (s_busy && s_wait > 0) begin
      s_wait--; srdy = 1'b0;
    end else if (s_busy && s_hold > 0) begin
      if (!srdy) srdata = $urandom();
      srdy = 1'b1; s_hold--;
    end else begin
      srdy = 1'b0;
    end
    if (!srdy) srdata = $urandom();
    err_clr = ($urandom_range(99) < clr_pct);
  endtask

  initial begin
    int w;
    sel = 2'b00; wr = 2'b00;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    srdy = 1'b0; srdata = '0; err_clr = 1'b0;
    repeat (3) cycle();
    rst = 1'b0;
    auto_en[0] = 1'b1;
    repeat (40) cycle();
    fix = 1'b0; auto_en[1] = 1'b1;
    repeat (600) cycle();
    hang_pct = 30; clr_pct = 10;
    repeat (800) cycle();
    hang_pct = 5; clr_pct = 5;
    for (int k = 0; k < 5; k++) begin
      w = 0;
      while (s_sel !== 1'b1 && w < 100) begin
        cycle();
        w++;
      end
      chk("rst_wait", w < 100, 1'b1);
      cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      repeat (30) cycle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
